// File: rtl/awg_param_ctrl.sv
// ---------------------------------------------------------------------------
// awg_param_ctrl
//
// Purpose:
//   Control front end for saw_gen. Parses byte-serial command frames
//   (HEADER, CMD, D_HI, D_LO [, CKS]) arriving from a UART receiver.
//   Parameter writes land in shadow registers. A COMMIT command copies every
//   shadow to the live outputs on a single clock edge, so the generator never
//   sees a half-updated parameter set.
//
// Configuration:
//   AWG_CKSUM_EN - when defined, every frame carries a fifth checksum byte
//                  (CMD ^ D_HI ^ D_LO). A mismatch rejects the frame with
//                  error code 4 before any other check. When undefined,
//                  frames are four bytes and code 4 never occurs.
//
// Parameters:
//   TIMEOUT_CYCLES - clocks allowed between bytes of one frame before abort
//   HEADER         - frame start byte
//
// Ports:
//   clk_i        system clock, all logic on the rising edge
//   rst_i        synchronous active-high reset
//   rx_data_i    command byte
//   rx_valid_i   rx_data_i valid; consumed when rx_valid_i & rx_ready_o
//   rx_ready_o   byte can be accepted (low only while executing a frame)
//   freq_o       live phase-accumulator step
//   amp_o        live amplitude divisor (never 0)
//   phase_o      live channel-B phase offset
//   en_o         live output enable
//   cmd_ok_o     one-cycle pulse, frame executed
//   cmd_err_o    one-cycle pulse, frame rejected or aborted
//   err_code_o   reason for the last cmd_err_o pulse:
//                1 unknown cmd, 2 range, 3 timeout, 4 checksum; 0 after reset
// ---------------------------------------------------------------------------
module awg_param_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  HEADER         = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [11:0] freq_o,
  output logic [2:0]  amp_o,
  output logic [7:0]  phase_o,
  output logic        en_o,
  output logic        cmd_ok_o,
  output logic        cmd_err_o,
  output logic [2:0]  err_code_o
);

  // Wide enough to hold TIMEOUT_CYCLES-1 even when TIMEOUT_CYCLES is 1.
  localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ERR_CMD   = 3'd1;
  localparam logic [2:0] ERR_RANGE = 3'd2;
  localparam logic [2:0] ERR_TMO   = 3'd3;
  localparam logic [2:0] ERR_CKS   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DHI,
    S_DLO,
`ifdef AWG_CKSUM_EN
    S_CKS,
`endif
    S_EXEC
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    dhi_q, dhi_d;
  logic [7:0]    dlo_q, dlo_d;
  logic [11:0]   freq_sh_q, freq_sh_d;
  logic [2:0]    amp_sh_q, amp_sh_d;
  logic [7:0]    phase_sh_q, phase_sh_d;
  logic          en_sh_q, en_sh_d;
  logic [11:0]   freq_q, freq_d;
  logic [2:0]    amp_q, amp_d;
  logic [7:0]    phase_q, phase_d;
  logic          en_q, en_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic [2:0]    code_q, code_d;

  logic          byte_acc;
  logic          timed_out;
  logic [15:0]   d_word;
  logic          cks_bad;

`ifdef AWG_CKSUM_EN
  logic [7:0]    cks_q, cks_d;
  assign cks_bad = (cks_q != (cmd_q ^ dhi_q ^ dlo_q));
`else
  assign cks_bad = 1'b0;
`endif

  assign rx_ready_o = (state_q != S_EXEC);
  assign byte_acc   = rx_valid_i && rx_ready_o;
  assign timed_out  = (timer_q == TLAST);
  assign d_word     = {dhi_q, dlo_q};

  assign freq_o     = freq_q;
  assign amp_o      = amp_q;
  assign phase_o    = phase_q;
  assign en_o       = en_q;
  assign cmd_ok_o   = ok_q;
  assign cmd_err_o  = err_q;
  assign err_code_o = code_q;

  // Frame parser, inter-byte timeout and command execution. Validation is
  // deferred to EXEC so a bad frame is always consumed in full first.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cmd_d      = cmd_q;
    dhi_d      = dhi_q;
    dlo_d      = dlo_q;
`ifdef AWG_CKSUM_EN
    cks_d      = cks_q;
`endif
    freq_sh_d  = freq_sh_q;
    amp_sh_d   = amp_sh_q;
    phase_sh_d = phase_sh_q;
    en_sh_d    = en_sh_q;
    freq_d     = freq_q;
    amp_d      = amp_q;
    phase_d    = phase_q;
    en_d       = en_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;

    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (byte_acc && (rx_data_i == HEADER)) begin
          state_d = S_CMD;
        end
      end

      S_EXEC: begin
        timer_d = '0;
        state_d = S_IDLE;
        if (cks_bad) begin
          err_d  = 1'b1;
          code_d = ERR_CKS;
        end else begin
          unique case (cmd_q)
            8'h01: begin
              if (d_word <= 16'h0FFF) begin
                freq_sh_d = d_word[11:0];
                ok_d      = 1'b1;
              end else begin
                err_d  = 1'b1;
                code_d = ERR_RANGE;
              end
            end
            8'h02: begin
              if ((d_word >= 16'd1) && (d_word <= 16'd7)) begin
                amp_sh_d = d_word[2:0];
                ok_d     = 1'b1;
              end else begin
                err_d  = 1'b1;
                code_d = ERR_RANGE;
              end
            end
            8'h03: begin
              if (d_word <= 16'h00FF) begin
                phase_sh_d = d_word[7:0];
                ok_d       = 1'b1;
              end else begin
                err_d  = 1'b1;
                code_d = ERR_RANGE;
              end
            end
            8'h04: begin
              if (d_word <= 16'd1) begin
                en_sh_d = d_word[0];
                ok_d    = 1'b1;
              end else begin
                err_d  = 1'b1;
                code_d = ERR_RANGE;
              end
            end
            8'h05: begin
              freq_d  = freq_sh_q;
              amp_d   = amp_sh_q;
              phase_d = phase_sh_q;
              en_d    = en_sh_q;
              ok_d    = 1'b1;
            end
            default: begin
              err_d  = 1'b1;
              code_d = ERR_CMD;
            end
          endcase
        end
      end

      default: begin
        // Mid-frame states: an accepted byte always beats a timeout.
        if (byte_acc) begin
          timer_d = '0;
          unique case (state_q)
            S_CMD: begin
              cmd_d   = rx_data_i;
              state_d = S_DHI;
            end
            S_DHI: begin
              dhi_d   = rx_data_i;
              state_d = S_DLO;
            end
`ifdef AWG_CKSUM_EN
            S_DLO: begin
              dlo_d   = rx_data_i;
              state_d = S_CKS;
            end
            S_CKS: begin
              cks_d   = rx_data_i;
              state_d = S_EXEC;
            end
`else
            S_DLO: begin
              dlo_d   = rx_data_i;
              state_d = S_EXEC;
            end
`endif
            default: state_d = S_IDLE;
          endcase
        end else if (timed_out) begin
          timer_d = '0;
          state_d = S_IDLE;
          err_d   = 1'b1;
          code_d  = ERR_TMO;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
    endcase
  end

  // State and parameter registers. Reset restores both shadow and live sets
  // to the generator defaults and discards any partial frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      cmd_q      <= '0;
      dhi_q      <= '0;
      dlo_q      <= '0;
`ifdef AWG_CKSUM_EN
      cks_q      <= '0;
`endif
      freq_sh_q  <= 12'd1;
      amp_sh_q   <= 3'd1;
      phase_sh_q <= '0;
      en_sh_q    <= 1'b0;
      freq_q     <= 12'd1;
      amp_q      <= 3'd1;
      phase_q    <= '0;
      en_q       <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cmd_q      <= cmd_d;
      dhi_q      <= dhi_d;
      dlo_q      <= dlo_d;
`ifdef AWG_CKSUM_EN
      cks_q      <= cks_d;
`endif
      freq_sh_q  <= freq_sh_d;
      amp_sh_q   <= amp_sh_d;
      phase_sh_q <= phase_sh_d;
      en_sh_q    <= en_sh_d;
      freq_q     <= freq_d;
      amp_q      <= amp_d;
      phase_q    <= phase_d;
      en_q       <= en_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

endmodule

// File: tb/tb_awg_param_ctrl.sv
// ---------------------------------------------------------------------------
// tb_awg_param_ctrl
//
// Drives command frames into awg_param_ctrl and compares the pulses, error
// codes and live parameter outputs against a frame-level reference model.
// Directed scenarios come first, followed by randomized frames. Define
// AWG_CKSUM_EN for both files to exercise the checksum build.
// ---------------------------------------------------------------------------
module tb_awg_param_ctrl;

  localparam int          TO  = 40;
  localparam logic [7:0]  HDR = 8'hA5;

  logic        clk;
  logic        rst;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic [11:0] freq;
  logic [2:0]  amp;
  logic [7:0]  phase;
  logic        en;
  logic        cmdOk;
  logic        cmdErr;
  logic [2:0]  errCode;

  int checksTotal  = 0;
  int checksPassed = 0;

  // Reference model: shadow (m*) and live (l*) parameter sets.
  int mFreq, mAmp, mPhase, mEn;
  int lFreq, lAmp, lPhase, lEn;

  awg_param_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .HEADER        (HDR)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .rx_data_i (rxData),
    .rx_valid_i(rxValid),
    .rx_ready_o(rxReady),
    .freq_o    (freq),
    .amp_o     (amp),
    .phase_o   (phase),
    .en_o      (en),
    .cmd_ok_o  (cmdOk),
    .cmd_err_o (cmdErr),
    .err_code_o(errCode)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends even if the design wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checksTotal++;
    if (observed == expected) checksPassed++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  function automatic void modelReset();
    mFreq = 1; mAmp = 1; mPhase = 0; mEn = 0;
    lFreq = 1; lAmp = 1; lPhase = 0; lEn = 0;
  endfunction

  function automatic int liveExp();
    return lFreq * 4096 + lAmp * 512 + lPhase * 2 + lEn;
  endfunction

  function automatic int liveObs();
    return int'(freq) * 4096 + int'(amp) * 512 + int'(phase) * 2 + int'(en);
  endfunction

  function automatic int goodCks(input int c, input int dh, input int dl);
    return (c ^ dh ^ dl) & 255;
  endfunction

  // Applies the command rules to one complete frame and reports the outcome.
  function automatic void modelFrame(input int c, input int dh, input int dl,
                                     input bit cksBad, output int okExp, output int errExp);
    int d;
    d      = dh * 256 + dl;
    okExp  = 0;
    errExp = 0;
    if (cksBad) errExp = 4;
    else if (c == 1) begin
      if (d <= 4095) mFreq = d; else errExp = 2;
    end else if (c == 2) begin
      if (d >= 1 && d <= 7) mAmp = d; else errExp = 2;
    end else if (c == 3) begin
      if (d <= 255) mPhase = d; else errExp = 2;
    end else if (c == 4) begin
      if (d <= 1) mEn = d; else errExp = 2;
    end else if (c == 5) begin
      lFreq = mFreq; lAmp = mAmp; lPhase = mPhase; lEn = mEn;
    end else errExp = 1;
    if (errExp == 0) okExp = 1;
  endfunction

  // Offers one byte starting at a falling edge, waits for its acceptance
  // edge, and returns at the following falling edge with valid dropped.
  task automatic applyStimulus(input logic [7:0] b);
    int waitCnt;
    waitCnt = 0;
    rxData  = b;
    rxValid = 1'b1;
    while (!rxReady && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!rxReady) checkOutput("ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    rxValid = 1'b0;
  endtask

  // Sends a complete frame with random gaps and checks the EXEC cycle, the
  // result cycle and the cycle after it.
  task automatic sendFrame(input int c, input int dh, input int dl, input int ck);
    logic [7:0] frame[$];
    int okExp, errExp;
    bit cksBad;
    frame  = {HDR, 8'(c), 8'(dh), 8'(dl), 8'(ck)};
    cksBad = 1'b0;
`ifdef AWG_CKSUM_EN
    cksBad = (frame[4] != (frame[1] ^ frame[2] ^ frame[3]));
`else
    frame.delete(4);
`endif
    foreach (frame[i]) begin
      applyStimulus(frame[i]);
      if (i < frame.size() - 1) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    checkOutput("exec_ready", int'(rxReady), 0);
    checkOutput("exec_live", liveObs(), liveExp());
    modelFrame(int'(frame[1]), int'(frame[2]), int'(frame[3]), cksBad, okExp, errExp);
    @(negedge clk);
    checkOutput("ok_pulse", int'(cmdOk), okExp);
    checkOutput("err_pulse", int'(cmdErr), (errExp != 0) ? 1 : 0);
    if (errExp != 0) checkOutput("err_code", int'(errCode), errExp);
    checkOutput("live", liveObs(), liveExp());
    checkOutput("idle_ready", int'(rxReady), 1);
    @(negedge clk);
    checkOutput("pulse_clear", int'({cmdOk, cmdErr}), 0);
  endtask

  task automatic sendGood(input int c, input int dh, input int dl);
    sendFrame(c, dh, dl, goodCks(c, dh, dl));
  endtask

  // Drops a byte in IDLE and checks nothing reacts.
  task automatic sendJunk(input logic [7:0] b);
    applyStimulus(b);
    checkOutput("junk_ready", int'(rxReady), 1);
    checkOutput("junk_pulse0", int'({cmdOk, cmdErr}), 0);
    @(negedge clk);
    checkOutput("junk_pulse1", int'({cmdOk, cmdErr}), 0);
    checkOutput("junk_live", liveObs(), liveExp());
  endtask

  initial begin
    int r, d, c, cnt;
    logic [7:0] jb;

    rst     = 1'b1;
    rxValid = 1'b0;
    rxData  = 8'h00;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", int'(rxReady), 1);
    checkOutput("rst_pulses", int'({cmdOk, cmdErr}), 0);
    checkOutput("rst_code", int'(errCode), 0);
    checkOutput("rst_live", liveObs(), liveExp());
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] freq write then commit");
    sendGood(8'h01, 8'h03, 8'hE8);
    checkOutput("freq_before_commit", int'(freq), 1);
    sendGood(8'h05, 8'h00, 8'h00);
    checkOutput("freq_1000", int'(freq), 1000);

    $display("[TB] amp range errors");
    sendGood(8'h02, 8'h00, 8'h00);
    checkOutput("amp0_code", int'(errCode), 2);
    sendGood(8'h02, 8'h00, 8'h08);
    checkOutput("amp8_code", int'(errCode), 2);
    sendGood(8'h05, 8'h00, 8'h00);
    checkOutput("amp_still_1", int'(amp), 1);

    $display("[TB] inter-byte timeout");
    applyStimulus(HDR);
    applyStimulus(8'h01);
    cnt = 0;
    while (!cmdErr && cnt < 3 * TO) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("timeout_cycles", cnt, TO);
    checkOutput("timeout_code", int'(errCode), 3);
    checkOutput("timeout_ready", int'(rxReady), 1);
    @(negedge clk);
    sendGood(8'h03, 8'h00, 8'h22);

    $display("[TB] junk then unknown command");
    sendJunk(8'h3C);
    sendJunk(8'h7F);
    sendGood(8'h09, 8'h00, 8'h00);
    checkOutput("unknown_code", int'(errCode), 1);

    $display("[TB] reset mid-frame");
    sendGood(8'h01, 8'h01, 8'h23);
    sendGood(8'h03, 8'h00, 8'h40);
    applyStimulus(HDR);
    applyStimulus(8'h01);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    checkOutput("midrst_code", int'(errCode), 0);
    checkOutput("midrst_ready", int'(rxReady), 1);
    sendGood(8'h05, 8'h00, 8'h00);
    checkOutput("midrst_freq", int'(freq), 1);
    checkOutput("midrst_phase", int'(phase), 0);
    checkOutput("midrst_en", int'(en), 0);

`ifdef AWG_CKSUM_EN
    $display("[TB] checksum frames");
    sendFrame(8'h04, 8'h00, 8'h01, 8'h05);
    sendFrame(8'h04, 8'h00, 8'h01, 8'h00);
    checkOutput("cks_code", int'(errCode), 4);
`endif

    $display("[TB] randomized frames");
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r == 8) begin
        jb = 8'($urandom_range(0, 255));
        if (jb == HDR) jb = 8'h00;
        sendJunk(jb);
        r = $urandom_range(0, 7);
      end
      if (r <= 1)      c = 1;
      else if (r == 2) c = 2;
      else if (r == 3) c = 3;
      else if (r == 4) c = 4;
      else if (r <= 6) c = 5;
      else             c = (($urandom_range(0, 3) == 0) ? 0 : $urandom_range(6, 255));
      if ($urandom_range(0, 1) == 1) begin
        if (c == 1)      d = $urandom_range(0, 4095);
        else if (c == 2) d = $urandom_range(0, 9);
        else if (c == 3) d = $urandom_range(0, 255);
        else if (c == 4) d = $urandom_range(0, 2);
        else             d = $urandom_range(0, 65535);
      end else begin
        d = $urandom_range(0, 65535);
      end
      if ($urandom_range(0, 7) == 0)
        sendFrame(c, d / 256, d % 256, $urandom_range(0, 255));
      else
        sendGood(c, d / 256, d % 256);
    end

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
